// File: rtl/mul8_seq_ctrl_pkg.sv
// Shared definitions for the sequential multiplier: state encoding, last step
// index and the per-step shift of each partial product.
package mul8_seq_ctrl_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   localparam logic [1:0] LAST_STEP = 2'd3;

   // Steps 0..3 multiply LL, HL, LH, HH; cross terms land at half-width offset.
   function automatic int step_shift(input logic [1:0] step, input int half);
      int sh;
      case (step)
         2'd0:    sh = 0;
         2'd1:    sh = half;
         2'd2:    sh = half;
         default: sh = 2 * half;
      endcase
      return sh;
   endfunction

endpackage

// File: rtl/mul8_seq_ctrl_mul_half_unit.sv
// Combinational half-width unsigned multiplier shared across all four steps.
module mul_half_unit #(
   parameter int H = 4
) (
   input  logic [H-1:0]   a,
   input  logic [H-1:0]   b,
   output logic [2*H-1:0] p
);

   assign p = {{H{1'b0}}, a} * {{H{1'b0}}, b};

endmodule

// File: rtl/mul8_seq_ctrl.sv
// Sequential WxW unsigned multiplier: one (W/2)x(W/2) multiplier reused over
// four cycles, partial products accumulated into a 2W-bit result.
module mul8_seq_ctrl
   import mul8_seq_ctrl_pkg::*;
#(
   parameter int W = 8
) (
   input  logic           clk,
   input  logic           rst,
   input  logic           load,
   input  logic [W-1:0]   A,
   input  logic [W-1:0]   B,
   output logic [2*W-1:0] P,
   output logic           done,
   output logic           busy
);

   localparam int H = W / 2;

   state_t           state_reg, state_next;
   logic [W-1:0]     a_reg, a_next;
   logic [W-1:0]     b_reg, b_next;
   logic [2*W-1:0]   acc_reg, acc_next;
   logic [1:0]       step_reg, step_next;
   logic [2*W-1:0]   p_reg, p_next;
   logic             done_reg, done_next;
   logic             busy_reg, busy_next;

   logic [H-1:0]     op_a, op_b;
   logic [W-1:0]     pp;
   logic [2*W-1:0]   pp_shifted;
   logic [2*W-1:0]   acc_sum;

   // Step bit 0 selects the high half of A, bit 1 the high half of B.
   assign op_a = step_reg[0] ? a_reg[W-1:H] : a_reg[H-1:0];
   assign op_b = step_reg[1] ? b_reg[W-1:H] : b_reg[H-1:0];

   mul_half_unit #(.H(H)) u_mul (
      .a (op_a),
      .b (op_b),
      .p (pp)
   );

   assign pp_shifted = {{W{1'b0}}, pp} << step_shift(step_reg, H);
   assign acc_sum    = acc_reg + pp_shifted;

   always_ff @(posedge clk) begin
      if (rst) begin
         state_reg <= IDLE;
         a_reg     <= '0;
         b_reg     <= '0;
         acc_reg   <= '0;
         step_reg  <= '0;
         p_reg     <= '0;
         done_reg  <= 1'b0;
         busy_reg  <= 1'b0;
      end else begin
         state_reg <= state_next;
         a_reg     <= a_next;
         b_reg     <= b_next;
         acc_reg   <= acc_next;
         step_reg  <= step_next;
         p_reg     <= p_next;
         done_reg  <= done_next;
         busy_reg  <= busy_next;
      end
   end

   always_comb begin
      state_next = state_reg;
      a_next     = a_reg;
      b_next     = b_reg;
      acc_next   = acc_reg;
      step_next  = step_reg;
      p_next     = p_reg;
      done_next  = done_reg;
      busy_next  = busy_reg;

      case (state_reg)
         IDLE, DONE: begin
            if (load) begin
               a_next     = A;
               b_next     = B;
               acc_next   = '0;
               step_next  = 2'd0;
               busy_next  = 1'b1;
               done_next  = 1'b0;
               state_next = RUN;
            end
         end
         RUN: begin
            acc_next  = acc_sum;
            step_next = step_reg + 2'd1;
            // The final partial product is folded straight into P on this edge.
            if (step_reg == LAST_STEP) begin
               p_next     = acc_sum;
               done_next  = 1'b1;
               busy_next  = 1'b0;
               state_next = DONE;
            end
         end
         default: begin
            state_next = IDLE;
            busy_next  = 1'b0;
            done_next  = 1'b0;
         end
      endcase
   end

   assign P    = p_reg;
   assign done = done_reg;
   assign busy = busy_reg;

endmodule

// File: tb/tb_mul8_seq_ctrl.sv
// Bench for mul8_seq_ctrl: directed cases plus random operands, checked
// against plain integer multiplication and the 4-cycle handshake timing.
module tb_mul8_seq_ctrl;

   localparam int W = 8;

   logic           clk = 1'b0;
   logic           rst;
   logic           load;
   logic [W-1:0]   A;
   logic [W-1:0]   B;
   logic [2*W-1:0] P;
   logic           done;
   logic           busy;

   int errors = 0;
   int checks = 0;
   logic [2*W-1:0] model_p;

   always #5 clk = ~clk;

   mul8_seq_ctrl #(.W(W)) dut (
      .clk  (clk),
      .rst  (rst),
      .load (load),
      .A    (A),
      .B    (B),
      .P    (P),
      .done (done),
      .busy (busy)
   );

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   // Load a*b, check busy for 4 cycles with P held, then done and the product.
   // glitch_at in 0..3 pulses a stray load with random operands during RUN.
   task automatic mul_txn(input logic [W-1:0] a, input logic [W-1:0] b, input int glitch_at);
      logic [2*W-1:0] expv;
      expv = (2*W)'(32'(a) * 32'(b));
      load = 1'b1;
      A = a;
      B = b;
      tick();
      load = 1'b0;
      A = W'($urandom);
      B = W'($urandom);
      for (int i = 0; i < 4; i++) begin
         check("busy_high", 32'(busy), 32'd1);
         check("done_low", 32'(done), 32'd0);
         check("p_hold", 32'(P), 32'(model_p));
         if (i == glitch_at) begin
            load = 1'b1;
            A = W'($urandom);
            B = W'($urandom);
         end
         tick();
         load = 1'b0;
      end
      check("busy_end", 32'(busy), 32'd0);
      check("done_set", 32'(done), 32'd1);
      check("product", 32'(P), 32'(expv));
      model_p = expv;
      $display("txn a=0x%02h b=0x%02h glitch=%0d P=0x%04h expected=0x%04h", a, b, glitch_at, P, expv);
   endtask

   task automatic hold_idle(input int n);
      for (int i = 0; i < n; i++) begin
         tick();
         check("done_hold", 32'(done), 32'd1);
         check("busy_hold", 32'(busy), 32'd0);
         check("p_stable", 32'(P), 32'(model_p));
      end
   endtask

   initial begin
      rst  = 1'b1;
      load = 1'b0;
      A    = '0;
      B    = '0;
      model_p = '0;
      tick();
      tick();
      check("rst_p", 32'(P), 32'd0);
      check("rst_done", 32'(done), 32'd0);
      check("rst_busy", 32'(busy), 32'd0);

      // Reset wins over a simultaneous load.
      load = 1'b1;
      A = 8'h12;
      B = 8'h34;
      tick();
      check("rst_over_load", 32'(busy), 32'd0);
      rst  = 1'b0;
      load = 1'b0;
      tick();
      check("idle_busy", 32'(busy), 32'd0);
      check("idle_done", 32'(done), 32'd0);
      $display("txn reset P=0x%04h done=%b busy=%b", P, done, busy);

      mul_txn(8'h12, 8'h34, -1);
      mul_txn(8'hFF, 8'hFF, -1);
      hold_idle(10);
      $display("txn hold10 P=0x%04h done=%b", P, done);
      mul_txn(8'h00, 8'hAB, -1);
      mul_txn(8'h10, 8'h10, 1);
      // Back-to-back: second load accepted in DONE on the very next edge.
      mul_txn(8'h0F, 8'h11, -1);
      mul_txn(8'h80, 8'h02, -1);

      // Abort 0xAA*0x55 during its third busy cycle.
      load = 1'b1;
      A = 8'hAA;
      B = 8'h55;
      tick();
      load = 1'b0;
      tick();
      tick();
      check("abort_busy_pre", 32'(busy), 32'd1);
      rst = 1'b1;
      tick();
      rst = 1'b0;
      check("abort_p", 32'(P), 32'd0);
      check("abort_done", 32'(done), 32'd0);
      check("abort_busy", 32'(busy), 32'd0);
      model_p = '0;
      $display("txn abort P=0x%04h done=%b busy=%b", P, done, busy);
      tick();
      mul_txn(8'h03, 8'h07, -1);

      for (int t = 0; t < 25; t++) begin
         logic [W-1:0] ra;
         logic [W-1:0] rb;
         ra = W'($urandom);
         rb = W'($urandom);
         mul_txn(ra, rb, int'($urandom_range(0, 7)));
         hold_idle(int'($urandom_range(0, 2)));
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/mul8_seq_ctrl.md
Name: mul8_seq_ctrl

Overview:
Sequential 8x8 unsigned multiplier controller. It time-multiplexes one combinational half-width (4x4) multiplier across the four partial products LL, HL, LH and HH, and accumulates them into a 16-bit result. It provides the same load/done/busy handshake as the combinational multiply8 path. It is a smaller-area drop-in where a 4-cycle latency is acceptable.

Parameters:
- W, 8, operand width. Must be even. The sub-multiplier is W/2 x W/2 and the result is 2W bits.

Ports:
- clk  input  1  system clock; everything updates on the rising edge.
- rst  input  1  synchronous, active-high reset.
- load  input  1  start request; sampled on the rising edge.
- A  input  W  multiplicand; captured when load is accepted.
- B  input  W  multiplier; captured when load is accepted.
- P  output  2W  product; registered, and held stable while done=1.
- done  output  1  result valid; registered.
- busy  output  1  computation in progress; registered.

Behaviour:
- Reset (rst=1 at an edge):
  - state=IDLE; P=0, done=0, busy=0; internal accumulator, step counter and operand registers cleared.
  - rst overrides load at the same edge.
- States: IDLE, RUN, DONE.
- IDLE or DONE with load=1 at an edge:
  - capture A→a_r and B→b_r; acc=0, step=0.
  - go to RUN; busy=1, done=0.
  - P keeps its previous value until the new result is written.
- IDLE with load=0: stay; outputs hold.
- DONE with load=0: stay; done=1 and P hold indefinitely.
- RUN, each edge: acc += pp(step) shifted per step, then step++.
  - step 0: a_r[lo]*b_r[lo], shift 0.
  - step 1: a_r[hi]*b_r[lo], shift W/2.
  - step 2: a_r[lo]*b_r[hi], shift W/2.
  - step 3: a_r[hi]*b_r[hi], shift W.
- Arithmetic: 2W-bit unsigned adds, zero-extended. No overflow is possible; max is (2^W-1)^2.
- At the step-3 edge:
  - P = acc + pp3<<W, computed in the same edge (no extra cycle).
  - done=1, busy=0; state=DONE.
- Latency: load sampled at edge n → busy=1 for edges n+1..n+4 → done=1 and P valid after edge n+4. That is 4 cycles with busy high.
- load while in RUN is ignored: no restart, and the captured operands are unchanged.
- busy and done are never both 1.
- rst in the middle of RUN aborts the computation: all outputs go to 0 at that edge.
- A and B are don't-care except at the accepting edge.

Decomposition:
- Shared include file holds:
  - localparams for the state encoding (IDLE=2'd0, RUN=2'd1, DONE=2'd2);
  - LAST_STEP=2'd3;
  - the shift amounts per step.
- One sub-module, mul_half_unit: a combinational (W/2)x(W/2)→W unsigned multiplier.
- The controller owns the operand muxing by step, the shifter, the accumulator and the FSM.

Test Plan:
- Reset, then load with A=0x12, B=0x34 → busy high 4 cycles, then done=1 and P=0x03A8.
- A=0xFF, B=0xFF → P=0xFE01 after 4 busy cycles; done then held for 10 idle cycles with P unchanged.
- A=0x00, B=0xAB → P=0x0000 with done=1. Also check a prior nonzero P is overwritten.
- Start A=0x10, B=0x10, then pulse load with A=0x02, B=0x03 on busy cycle 2 → ignored; P=0x0100 and the 4-cycle latency is preserved.
- Load in DONE (back-to-back): first 0x0F*0x11 → P=0x00FF, then load 0x80*0x02 on the next edge → done drops at the following edge, then P=0x0100.
- Assert rst during busy cycle 3 of 0xAA*0x55 → P=0, done=0, busy=0 next cycle. A fresh load of 0x03*0x07 then gives P=0x0015.
